// File: rtl/chrisruk_matrix_pkg.sv
// Shared constants for the 8x8 APA102 digit matrix: frame layout, pixel words,
// glyph ROMs and the frame-sequencer state encoding.
package chrisruk_matrix_pkg;

    localparam int LED_COUNT   = 64;
    localparam int START_BITS  = 32;
    localparam int PIXEL_WORDS = 64;
    localparam int END_BITS    = 32;
    localparam int WORD_BITS   = 32;

    localparam int BIT_CNT_W = 5;
    localparam int LED_CNT_W = 6;

    // Header 0xE0 | brightness, then blue, green, red.
    localparam logic [31:0] LIT_WORD   = 32'hE400_0040;
    localparam logic [31:0] UNLIT_WORD = 32'hE000_0000;

    // One byte per row, bit 7 is the leftmost column.
    localparam logic [7:0] GLYPH_ZERO [8] = '{
        8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00
    };
    localparam logic [7:0] GLYPH_ONE [8] = '{
        8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00
    };

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_PIXELS = 2'd1,
        ST_END    = 2'd2
    } state_t;

    function automatic logic glyph_pixel(input logic sel, input logic [LED_CNT_W-1:0] led);
        logic [7:0] row_bits;
        row_bits = sel ? GLYPH_ONE[led[5:3]] : GLYPH_ZERO[led[5:3]];
        return row_bits[3'd7 - led[2:0]];
    endfunction

endpackage

// File: rtl/chrisruk_matrix_clkdiv.sv
// Strip clock generator: toggles clock_1 every MAX_COUNT system clocks and
// flags the system-clock edge on which clock_1 falls.
module chrisruk_matrix_clkdiv #(
    parameter int MAX_COUNT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic clock_1,
    output logic fall
);

    logic [15:0] count;
    logic        terminal;

    assign terminal = (count == 16'(MAX_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            clock_1 <= 1'b0;
        end else if (terminal) begin
            count   <= '0;
            clock_1 <= ~clock_1;
        end else begin
            count   <= count + 16'd1;
        end
    end

    // Combinational so the data register updates on the very edge clock_1 falls.
    assign fall = terminal & clock_1;

endmodule

// File: rtl/chrisruk_matrix.sv
// APA102 8x8 matrix driver showing digit "0" or "1" as an endless frame stream.
// Optional build macro CHRISRUK_MATRIX_BORDER_EN also lights the outer ring of pixels.
import chrisruk_matrix_pkg::*;

module chrisruk_matrix #(
    parameter int MAX_COUNT = 1000
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk;
    logic rst_n;
    logic digit1;
    logic unused_in;

    assign clk       = io_in[0];
    assign rst_n     = io_in[1];
    assign digit1    = io_in[2];
    assign unused_in = ^io_in[7:3];

    logic clock_1;
    logic fall;

    chrisruk_matrix_clkdiv #(
        .MAX_COUNT(MAX_COUNT)
    ) u_clkdiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .clock_1(clock_1),
        .fall   (fall)
    );

    state_t                 state, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_next;
    logic [LED_CNT_W-1:0]   led_cnt, led_next;
    logic                   glyph_sel;
    logic                   strip;
    logic                   bit_value;
    logic                   pix_lit;
    logic [WORD_BITS-1:0]   pix_word;

    function automatic logic on_border(input logic [LED_CNT_W-1:0] led);
        return (led[5:3] == 3'd0) || (led[5:3] == 3'd7) ||
               (led[2:0] == 3'd0) || (led[2:0] == 3'd7);
    endfunction

    // The counters always name the bit currently on strip; reset leaves START bit 0 (a zero) presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_START;
            bit_cnt   <= '0;
            led_cnt   <= '0;
            strip     <= 1'b0;
            glyph_sel <= 1'b0;
        end else begin
            if (state == ST_START && bit_cnt == '0)
                glyph_sel <= digit1;
            if (fall) begin
                state   <= state_next;
                bit_cnt <= bit_next;
                led_cnt <= led_next;
                strip   <= bit_value;
            end
        end
    end

    always_comb begin
        state_next = state;
        bit_next   = bit_cnt;
        led_next   = led_cnt;
        if (fall) begin
            bit_next = bit_cnt + 5'd1;
            if (bit_cnt == 5'(WORD_BITS - 1)) begin
                unique case (state)
                    ST_START: begin
                        state_next = ST_PIXELS;
                        led_next   = '0;
                    end
                    ST_PIXELS: begin
                        if (led_cnt == 6'(LED_COUNT - 1))
                            state_next = ST_END;
                        led_next = led_cnt + 6'd1;
                    end
                    ST_END: state_next = ST_START;
                    default: state_next = ST_START;
                endcase
            end
        end
    end

    // Value of the bit that becomes current after the next clock_1 fall, MSB first.
    always_comb begin
        pix_lit = glyph_pixel(glyph_sel, led_next);
`ifdef CHRISRUK_MATRIX_BORDER_EN
        pix_lit = pix_lit | on_border(led_next);
`endif
        pix_word  = pix_lit ? LIT_WORD : UNLIT_WORD;
        bit_value = 1'b0;
        unique case (state_next)
            ST_START:  bit_value = 1'b0;
            ST_PIXELS: bit_value = pix_word[5'd31 - bit_next];
            ST_END:    bit_value = 1'b1;
            default:   bit_value = 1'b0;
        endcase
    end

    assign io_out = {6'b00_0000, strip, clock_1};

endmodule

// File: tb/tb_chrisruk_matrix.sv
// Self-checking bench for chrisruk_matrix: decodes the serial stream word by word
// against a reference frame model held in a scoreboard queue.
module tb_chrisruk_matrix;

    localparam int MC         = 3;
    localparam int FRAME_BITS = 2112;
    localparam int FRAME_CYC  = FRAME_BITS * 2 * MC;
    localparam logic [31:0] LIT   = 32'hE400_0040;
    localparam logic [31:0] UNLIT = 32'hE000_0000;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       digit1 = 1'b0;
    logic [4:0] spare  = 5'b10101;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {spare, digit1, rst_n, clk};

    chrisruk_matrix #(.MAX_COUNT(MC)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];
    logic [31:0] cap[66];
    int rise_cyc, fall_cyc;
    int frame_rise0, frame_fall1;

    logic [7:0] g0[8] = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
    logic [7:0] g1[8] = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};

    function automatic logic [31:0] model_word(input logic sel, input int w);
        int idx, row, col;
        logic [7:0] row_bits;
        logic lit;
        if (w == 0) return 32'h0000_0000;
        if (w == 65) return 32'hFFFF_FFFF;
        idx = w - 1;
        row = idx / 8;
        col = idx % 8;
        row_bits = sel ? g1[row] : g0[row];
        lit = row_bits[7 - col];
`ifdef CHRISRUK_MATRIX_BORDER_EN
        if (row == 0 || row == 7 || col == 0 || col == 7) lit = 1'b1;
`endif
        return lit ? LIT : UNLIT;
    endfunction

    task automatic push_frame(input logic sel);
        for (int w = 0; w < 66; w++) sb.push_back(model_word(sel, w));
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic get_bit(output logic b);
        int n;
        n = 0;
        while (io_out[0] === 1'b1 && n < 4 * MC) begin
            @(posedge clk); #1; n++;
            if (io_out[0] !== 1'b1) fall_cyc = cyc;
        end
        while (io_out[0] !== 1'b1 && n < 8 * MC) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        assert (io_out[0] === 1'b1) else begin
            fails++;
            $error("FAIL clock_1_rise: got no rise in %0d cycles, required a rise", 8 * MC);
        end
        rise_cyc = cyc;
        b = io_out[1];
    endtask

    // abort_word >= 0: assert reset right after bit 0 of that word and stop.
    task automatic run_frame(input int abort_word, input int toggle_word, output int start_cyc);
        logic [31:0] word;
        logic [31:0] exp;
        logic bt;
        start_cyc = 0;
        for (int w = 0; w < 66; w++) begin
            word = '0;
            for (int b = 0; b < 32; b++) begin
                get_bit(bt);
                if (w == 0 && b == 0) begin
                    start_cyc   = rise_cyc;
                    frame_rise0 = rise_cyc;
                end
                if (w == 0 && b == 1) frame_fall1 = fall_cyc;
                word = {word[30:0], bt};
                if (w == abort_word && b == 0) begin
                    check("pre_reset_clock_1", {31'd0, io_out[0]}, 32'd1);
                    check("pre_reset_strip_1", {31'd0, io_out[1]}, 32'd1);
                    rst_n = 1'b0;
                    #1;
                    check("midreset_clock_1", {31'd0, io_out[0]}, 32'd0);
                    check("midreset_strip_1", {31'd0, io_out[1]}, 32'd0);
                    sb.delete();
                    return;
                end
            end
            cap[w] = word;
            if (sb.size() == 0) exp = 32'hDEAD_BEEF;
            else exp = sb.pop_front();
            check($sformatf("word%0d", w), word, exp);
            if (w == toggle_word) digit1 = ~digit1;
        end
    endtask

    int rel, s1, s2, s3, s4;

    initial begin
        digit1 = 1'b0;
        rst_n  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_clock_1", {31'd0, io_out[0]}, 32'd0);
        check("reset_strip_1", {31'd0, io_out[1]}, 32'd0);
        check("reset_unused_out", {26'd0, io_out[7:2]}, 32'd0);

        // Frame 1: glyph "0", switch to "1" mid-PIXELS.
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        push_frame(1'b0);
        run_frame(-1, 30, s1);
        check("first_rise_edge", frame_rise0 - rel, MC);
        check("first_fall_edge", frame_fall1 - rel, 2 * MC);
        check("f1_led2_word", cap[3], LIT);
        check("f1_led0_word", cap[1], UNLIT);
        check("f1_end_word", cap[65], 32'hFFFF_FFFF);

        // Frame 2: new glyph "1" takes effect; switch back mid-frame.
        push_frame(1'b1);
        run_frame(-1, 40, s2);
        check("frame_period", s2 - s1, FRAME_CYC);
        check("bit2113_start", cap[0], 32'h0000_0000);
        check("f2_led3_word", cap[4], LIT);
        check("f2_led0_word", cap[1], UNLIT);
        for (int c = 1; c <= 6; c++)
            check($sformatf("f2_row6_col%0d", c), cap[1 + 48 + c], LIT);

        // Frame 3: glyph "0", aborted by reset inside PIXELS.
        push_frame(1'b0);
        run_frame(20, -1, s3);
        repeat (5) @(posedge clk);
        #1;
        check("held_reset_clock_1", {31'd0, io_out[0]}, 32'd0);
        check("held_reset_strip_1", {31'd0, io_out[1]}, 32'd0);
        digit1 = 1'b1;

        // Frame 4: clean restart after reset with glyph "1".
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        push_frame(1'b1);
        run_frame(-1, -1, s4);
        check("restart_rise_edge", frame_rise0 - rel, MC);
        check("restart_fall_edge", frame_fall1 - rel, 2 * MC);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chrisruk_matrix.md
CHRISRUK_MATRIX -- requirements
Module: chrisruk_matrix

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 1000, meaning system-clock cycles per strip-clock half period (legal range 2..65535).
REQ-002 SHALL have port io_in[0] (clk), input, 1 bit: the single system clock, rising-edge.
REQ-003 SHALL have port io_in[1] (rst), input, 1 bit: reset, asynchronous and active-low (0 = in reset).
REQ-004 SHALL have port io_in[2] (digit1), input, 1 bit: glyph select, 1 = digit "1", 0 = digit "0".
REQ-005 SHALL have port io_in[7:3], input, 5 bits: unused and ignored.
REQ-006 SHALL have port io_out[0] (clock_1), output, 1 bit: LED strip serial clock.
REQ-007 SHALL have port io_out[1] (strip_1), output, 1 bit: LED strip serial data, MSB first.
REQ-008 SHALL drive io_out[7:2], output, 6 bits, constant 0.

Function
REQ-009 SHALL drive an 8x8 APA102-style matrix of 64 LEDs, index 0..63 row-major: row = idx/8, col = idx%8.
REQ-010 SHALL use a divider counting 0..MAX_COUNT-1; at terminal count it wraps to 0 and clock_1 toggles, giving a bit period of 2*MAX_COUNT clk cycles.
REQ-011 SHALL change strip_1 only on the clk edge where clock_1 falls, so data is stable at every clock_1 rising edge.
REQ-012 SHALL send each frame in order: START (32 zero bits), PIXELS (64 words of 32 bits), END (32 one bits), 2112 bits in total.
REQ-013 SHALL send a lit pixel as 0xE4_00_00_40 (header with brightness 4, then B, G, R) and an unlit pixel as 0xE0_00_00_00.
REQ-014 SHALL take glyph "0" rows 0..7 as 3C,66,6E,76,66,66,3C,00 and glyph "1" rows as 18,38,18,18,18,18,7E,00; row bit 7 = col 0.
REQ-015 SHALL sample digit1 only at the start of START; changes mid-frame take effect at the next frame.
REQ-016 SHALL follow END immediately with START of the next frame, repeating without gaps.
REQ-017 SHALL use FSM states START, PIXELS, END, with a 5-bit bit counter and a 6-bit LED counter; each state transitions when its last bit completes.

Reset
REQ-018 While rst=0, SHALL force clock_1=0, strip_1=0, divider=0, bit/LED counters=0, state START, and the latched glyph select=0.
REQ-019 After rst release, SHALL raise clock_1 at the MAX_COUNT-th clk edge, and the first bit clocked SHALL be START bit 0 (value 0).
REQ-020 If reset is asserted mid-frame, SHALL abort the frame immediately; no partial-frame resume.

Configuration
REQ-021 With macro CHRISRUK_MATRIX_BORDER_EN defined, SHALL also light every pixel in row 0, row 7, col 0 and col 7 (OR with glyph), using the lit-pixel word.
REQ-022 Without CHRISRUK_MATRIX_BORDER_EN, SHALL show the glyph only, exactly as in REQ-014.

Structure
REQ-023 SHALL place in package chrisruk_matrix_pkg: LED count (64), frame-section lengths (32/64/32), lit/unlit pixel words, both glyph ROM tables, and the FSM state enum.
REQ-024 SHALL implement the divider and clock_1 generation in sub-module chrisruk_matrix_clkdiv, with outputs clock_1 and a single-cycle fall strobe.

Verification
REQ-025 Reset test, MAX_COUNT=100: hold rst=0 for 10 cycles -> clock_1=0 and strip_1=0; after release, first clock_1 rise at clk edge 100 and fall at edge 200.
REQ-026 Start-frame test: capture the first 32 bits on clock_1 rising edges -> all 0.
REQ-027 Glyph "0" test, digit1=0: decode 64 pixel words -> lit set equals REQ-014 glyph "0"; LED 2 word is 0xE4000040 and LED 0 word is 0xE0000000.
REQ-028 Glyph "1" test, digit1=1: LED 3 is lit, LED 0 is unlit, and row 6 has cols 1..6 lit.
REQ-029 End and repeat test: bits 2081..2112 are all 1 and bit 2113 is 0; the frame period is 422400 clk cycles at MAX_COUNT=100.
REQ-030 Mid-frame test: toggle digit1 during PIXELS -> the current frame is unchanged and the next frame shows the new glyph; assert rst mid-frame -> outputs are 0 at once and the frame restarts cleanly after release.
